// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end for the single-port RAM: deserialises {cmd, payload}
// frames from MOSI and shifts RAM read data back out on MISO, MSB first.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t            state, state_nxt;
  logic [FW-2:0]     shreg;
  logic [CW-1:0]     bit_cnt;
  logic              frame_done;
  logic              rd_addr_seen;
  logic [DATA_W-1:0] tx_sreg;
  logic [TW-1:0]     tx_cnt;
  logic              tx_active;
  logic              tx_used;
  logic              last_bit;
  logic              tx_load;

  assign last_bit = (bit_cnt == CW'(FW - 1));
  // Read data is accepted once per READ_DATA frame, only after its rx_valid strobe.
  assign tx_load  = (state == READ_DATA) && frame_done && !tx_used && tx_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: if (SS_n) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_sreg      <= '0;
      tx_cnt       <= '0;
      tx_active    <= 1'b0;
      tx_used      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_valid <= 1'b0;
      if (SS_n || state == IDLE) begin
        // Abort or idle: drop any partial frame and any read in flight.
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        tx_cnt     <= '0;
        tx_active  <= 1'b0;
        tx_used    <= 1'b0;
        MISO       <= 1'b0;
      end else begin
        if (!frame_done) begin
          shreg   <= {shreg[FW-3:0], MOSI};
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            rx_data    <= {shreg, MOSI};
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
          end
        end
        if (tx_load) begin
          MISO      <= tx_data[DATA_W-1];
          tx_sreg   <= {tx_data[DATA_W-2:0], 1'b0};
          tx_cnt    <= TW'(DATA_W - 1);
          tx_active <= 1'b1;
          tx_used   <= 1'b1;
        end else if (tx_active) begin
          if (tx_cnt != '0) begin
            MISO    <= tx_sreg[DATA_W-1];
            tx_sreg <= {tx_sreg[DATA_W-2:0], 1'b0};
            tx_cnt  <= tx_cnt - 1'b1;
          end else begin
            MISO         <= 1'b0;
            tx_active    <= 1'b0;
            rd_addr_seen <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if: stimulus queues expected frames and
// per-cycle MISO/rx_valid values, a negedge monitor pops and compares.
module tb_spi_slave_if;
  localparam int DW = 8;
  localparam int FW = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic miso; logic rxv;} cyc_t;
  cyc_t          cyc_q[$];
  logic [FW-1:0] frm_q[$];
  logic          miso_plan[$];
  bit            rd_seen = 1'b0;

  cyc_t          mon_e;
  logic [FW-1:0] mon_f;
  logic          prev_rxv = 1'b0;
  int            cyc_n = 0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always @(negedge clk) begin
    cyc_n++;
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      checks++;
      if (MISO !== mon_e.miso) begin
        failures++;
        $display("FAIL miso cyc=%0d got=%b exp=%b", cyc_n, MISO, mon_e.miso);
      end
      checks++;
      if (rx_valid !== mon_e.rxv) begin
        failures++;
        $display("FAIL rx_valid cyc=%0d got=%b exp=%b", cyc_n, rx_valid, mon_e.rxv);
      end
    end
    if (rx_valid === 1'b1) begin
      checks++;
      if (prev_rxv) begin
        failures++;
        $display("FAIL rx_valid_twice cyc=%0d got=11 exp=10", cyc_n);
      end
      checks++;
      if (frm_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected cyc=%0d got=%h exp=none", cyc_n, rx_data);
      end else begin
        mon_f = frm_q.pop_front();
        if (rx_data !== mon_f) begin
          failures++;
          $display("FAIL rx_data cyc=%0d got=%h exp=%h", cyc_n, rx_data, mon_f);
        end
      end
    end
    prev_rxv = (rx_valid === 1'b1);
  end

  // One clock of stimulus; the expected MISO comes from the pending read plan.
  task automatic tick(input logic ss, input logic mosi, input logic tv,
                      input logic [DW-1:0] td, input logic rxv);
    SS_n = ss; MOSI = mosi; tx_valid = tv; tx_data = td;
    @(posedge clk); #1;
    cyc_q.push_back('{miso: (miso_plan.size() > 0) ? miso_plan.pop_front() : 1'b0, rxv: rxv});
  endtask

  task automatic do_reset(input int pre_bits, input logic [FW-1:0] f);
    if (pre_bits > 0) begin
      tick(1'b0, 1'($urandom), 1'b0, '0, 1'b0);
      for (int i = 0; i < pre_bits; i++) tick(1'b0, f[FW-1-i], 1'($urandom), 8'($urandom), 1'b0);
    end
    miso_plan.delete();
    rst_n = 1'b0;
    tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    rst_n = 1'b1;
    rd_seen = 1'b0;
    checks++;
    if (rx_data !== '0) begin
      failures++;
      $display("FAIL reset_rx_data got=%h exp=%h", rx_data, {FW{1'b0}});
    end
  endtask

  // One SS_n-low transaction: nbits < FW aborts the frame early.
  task automatic frame(input logic [FW-1:0] f, input int nbits, input bit do_tx,
                       input logic [DW-1:0] td, input int gap, input int shift_len);
    bit full, rdata, radd;
    full  = (nbits == FW);
    rdata = full && f[FW-1] && rd_seen;
    radd  = full && f[FW-1] && !rd_seen;
    tick(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == FW-1) frm_q.push_back(f);
      tick(1'b0, f[FW-1-i], 1'($urandom), 8'($urandom), i == FW-1);
    end
    if (full && rdata && do_tx) begin
      for (int i = 0; i < gap; i++) tick(1'b0, 1'($urandom), 1'b0, 8'($urandom), 1'b0);
      for (int b = DW-1; b >= 0; b--) miso_plan.push_back(td[b]);
      tick(1'b0, 1'($urandom), 1'b1, td, 1'b0);
      for (int i = 0; i < shift_len; i++) tick(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
      if (shift_len >= DW) rd_seen = 1'b0;
      miso_plan.delete();
    end else if (full) begin
      for (int i = 0; i < gap; i++)
        tick(1'b0, 1'($urandom), rdata ? 1'b0 : 1'($urandom), 8'($urandom), 1'b0);
    end
    if (radd) rd_seen = 1'b1;
    tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    do_reset(0, '0);
    frame(10'h0FE, FW, 1'b0, '0, 3, 0);
    frame(10'h1AA, FW, 1'b1, 8'h33, 4, 0);
    frame(10'h2FE, FW, 1'b0, '0, 2, 0);
    frame(10'h300, FW, 1'b1, 8'hA5, 2, 10);
    frame(10'h0FE, 6, 1'b0, '0, 0, 0);
    frame(10'h155, FW, 1'b0, '0, 1, 0);
    tick(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
    // Read address, then aborted read-data frames keep rd_addr_seen set.
    frame(10'h281, FW, 1'b0, '0, 1, 0);
    frame(10'h3F0, 5, 1'b0, '0, 0, 0);
    frame(10'h3F0, FW, 1'b1, 8'hC3, 1, 4);
    frame(10'h3F1, FW, 1'b1, 8'h96, 0, 9);
    frame(10'h2AA, FW, 1'b0, '0, 1, 0);
    do_reset(4, 10'h3C3);
    frame(10'h3C3, FW, 1'b1, 8'h5A, 6, 0);
    frame(10'h377, FW, 1'b1, 8'h81, 3, 9);
    frame(10'h0F0, 9, 1'b0, '0, 0, 0);
    do_reset(9, 10'h2F0);
    for (int n = 0; n < 60; n++) begin
      frame(10'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FW-1)) : FW,
            1'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(2, 9)));
    end
    @(negedge clk); #1;
    checks++;
    if (frm_q.size() != 0) begin
      failures++;
      $display("FAIL frames_left got=%0d exp=0", frm_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
